// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam int unsigned MAX_SEG_WIDTH = 16;
  localparam int unsigned PAIR_W        = MAX_SEG_WIDTH + 1;

  // Both carry-in variants of one segment, right-aligned; unused upper bits are zero.
  typedef struct packed {
    logic [PAIR_W-1:0] s1;
    logic [PAIR_W-1:0] s0;
  } seg_pair_t;

  function automatic int unsigned calc_nseg(input int unsigned width, input int unsigned seg_width);
    return ((width / seg_width) < 1) ? 1 : (width / seg_width);
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned seg_width);
    return (seg_width >= 1) && (seg_width <= MAX_SEG_WIDTH) &&
           (width >= seg_width) && ((width % seg_width) == 0);
  endfunction

endpackage

// File: rtl/csa_seg.sv
// One carry-select segment: SEG_WIDTH-bit add for carry-in 0 and carry-in 1.
module csa_seg
  import csa_pkg::*;
#(
  parameter int unsigned SEG_WIDTH = 4
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  output seg_pair_t            pair
);

  logic [SEG_WIDTH:0] t0;
  logic [SEG_WIDTH:0] t1;

  always_comb begin
    t0      = {1'b0, a} + {1'b0, b};
    t1      = t0 + (SEG_WIDTH + 1)'(1);
    pair    = '0;
    pair.s0 = PAIR_W'(t0);
    pair.s1 = PAIR_W'(t1);
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder with valid tagging, stall and carry-out counter.
// Optional build macro CSA_SAT_EN: saturate the result to 2^WIDTH-1 on carry-out.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEG_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 cin,
  input  logic                 cnt_clr,
  output logic                 out_valid,
  output logic [WIDTH:0]       sum,
  output logic [CNT_WIDTH-1:0] cout_cnt
);

  localparam int unsigned NSEG   = calc_nseg(WIDTH, SEG_WIDTH);
  localparam bit          CFG_OK = cfg_ok(WIDTH, SEG_WIDTH);

  if (!CFG_OK) begin : g_cfg_err
    $error("csa_pipe_adder: WIDTH must be a nonzero multiple of SEG_WIDTH (SEG_WIDTH <= MAX_SEG_WIDTH)");
  end

  seg_pair_t pair_d [NSEG];
  seg_pair_t pair_q [NSEG];
  logic      cin_q;
  logic      v1_q;

  for (genvar gk = 0; gk < NSEG; gk++) begin : g_seg
    csa_seg #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a    (in1[gk*SEG_WIDTH +: SEG_WIDTH]),
      .b    (in2[gk*SEG_WIDTH +: SEG_WIDTH]),
      .pair (pair_d[gk])
    );
  end

  logic [PAIR_W-1:0] sel_w;
  logic [WIDTH-1:0]  sum_lo;
  logic              carry;
  logic [WIDTH:0]    sum_d;
  logic              cnt_inc;

  // Carry-select chain: each segment's carry picks the next segment's precomputed word.
  always_comb begin
    carry  = cin_q;
    sum_lo = '0;
    sel_w  = '0;
    for (int unsigned k = 0; k < NSEG; k++) begin
      sel_w = carry ? pair_q[k].s1 : pair_q[k].s0;
      sum_lo[k*SEG_WIDTH +: SEG_WIDTH] = sel_w[SEG_WIDTH-1:0];
      carry = |(sel_w >> SEG_WIDTH);
    end
`ifdef CSA_SAT_EN
    sum_d = carry ? {1'b0, {WIDTH{1'b1}}} : {1'b0, sum_lo};
`else
    sum_d = {carry, sum_lo};
`endif
    cnt_inc = en && v1_q && carry && (cout_cnt != {CNT_WIDTH{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSEG; k++) pair_q[k] <= '0;
      cin_q     <= 1'b0;
      v1_q      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
    end else if (en) begin
      for (int unsigned k = 0; k < NSEG; k++) pair_q[k] <= pair_d[k];
      cin_q     <= cin;
      v1_q      <= in_valid;
      out_valid <= v1_q;
      sum       <= sum_d;
    end
  end

  // Clear wins over a same-cycle increment and works while stalled.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cout_cnt <= '0;
    end else if (cnt_inc) begin
      cout_cnt <= cout_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder (WIDTH=16, SEG_WIDTH=4, CNT_WIDTH=2); honours CSA_SAT_EN.
module tb_csa_pipe_adder;

  localparam int unsigned W       = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [W-1:0]     in1;
  logic [W-1:0]     in2;
  logic             cin;
  logic             cnt_clr;
  logic             out_valid;
  logic [W:0]       sum;
  logic [CNT_W-1:0] cout_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  csa_pipe_adder #(.WIDTH(W), .SEG_WIDTH(4), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in1(in1), .in2(in2),
    .cin(cin), .cnt_clr(cnt_clr), .out_valid(out_valid), .sum(sum), .cout_cnt(cout_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] sat_res(input logic [16:0] raw);
`ifdef CSA_SAT_EN
    return raw[16] ? 17'h0FFFF : raw;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: plain arithmetic result delayed by two enabled edges.
  bit          mv1, mov;
  logic [16:0] mraw1, mraw2;
  int          mcnt;

  always @(posedge clk) begin
    if (rst) begin
      mv1 <= 1'b0; mov <= 1'b0; mraw1 <= '0; mraw2 <= '0; mcnt <= 0;
    end else begin
      if (en) begin
        mv1   <= in_valid;
        mraw1 <= 17'(in1) + 17'(in2) + 17'(cin);
        mov   <= mv1;
        mraw2 <= mraw1;
      end
      if (cnt_clr) mcnt <= 0;
      else if (en && mv1 && mraw1[16] && mcnt < CNT_MAX) mcnt <= mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model out_valid", 32'(out_valid), 32'(mov));
      chk("model sum", 32'(sum), 32'(sat_res(mraw2)));
      chk("model cout_cnt", 32'(cout_cnt), 32'(mcnt));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in_valid = v; in1 = a; in2 = b; cin = c;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cnt_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    started = 1'b1;
    cyc();
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset sum", 32'(sum), 0);
    chk("reset cout_cnt", 32'(cout_cnt), 0);
    rst = 1'b0;

    // Latency: exactly two enabled edges.
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0);
    chk("lat early", 32'(out_valid), 0);
    cyc();
    chk("lat valid", 32'(out_valid), 1);
    chk("lat sum", 32'(sum), 32'h00100);
    cyc();
    chk("lat pulse end", 32'(out_valid), 0);

    // Full carry ripple, with and without carry-in.
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1); cyc();
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b0); cyc();
`ifdef CSA_SAT_EN
    chk("ripple cin1 sum", 32'(sum), 32'h0FFFF);
`else
    chk("ripple cin1 sum", 32'(sum), 32'h10000);
`endif
    chk("ripple cin1 cnt", 32'(cout_cnt), 1);
    drive(1'b0, '0, '0, 1'b0); cyc();
    chk("ripple cin0 sum", 32'(sum), 32'h0FFFF);
    chk("ripple cin0 cnt", 32'(cout_cnt), 1);
    cyc();

    // Back-to-back stream: sums 1,3,5,7.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, W'(i), W'(i), 1'b1);
      else drive(1'b0, '0, '0, 1'b0);
      cyc();
      if (i >= 1 && i <= 4) begin
        chk("stream valid", 32'(out_valid), 1);
        chk("stream sum", 32'(sum), 32'(2 * (i - 1) + 1));
      end
    end

    // Stall mid-stream, counter saturation at 3.
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    chk("clr cnt", 32'(cout_cnt), 0);
    drive(1'b1, 16'h8000, 16'h8000, 1'b0); cyc();
    drive(1'b1, 16'h8001, 16'h8000, 1'b0); cyc();
    chk("stall pre cnt", 32'(cout_cnt), 1);
    en = 1'b0;
    drive(1'b1, 16'h8002, 16'h8000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall valid", 32'(out_valid), 1);
      chk("stall sum", 32'(sum), 32'(sat_res(17'h10000)));
      chk("stall cnt", 32'(cout_cnt), 1);
    end
    en = 1'b1; cyc();
    chk("resume sum", 32'(sum), 32'(sat_res(17'h10001)));
    chk("resume cnt", 32'(cout_cnt), 2);
    drive(1'b1, 16'h8003, 16'h8000, 1'b0); cyc();
    drive(1'b1, 16'h8004, 16'h8000, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0); cyc(); cyc();
    chk("sat cnt", 32'(cout_cnt), 3);

    // Clear coincident with a carry-out result.
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0); cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    chk("clr prio valid", 32'(out_valid), 1);
    chk("clr prio cnt", 32'(cout_cnt), 0);

    // Clear while stalled.
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0); cyc();
    chk("pre stall clr cnt", 32'(cout_cnt), 1);
    en = 1'b0; cnt_clr = 1'b1; cyc();
    chk("stall clr cnt", 32'(cout_cnt), 0);
    chk("stall clr hold", 32'(out_valid), 1);
    en = 1'b1; cnt_clr = 1'b0; cyc();

    // Reset mid-stream discards in-flight work.
    drive(1'b1, 16'h0001, 16'h0002, 1'b0); cyc();
    drive(1'b1, 16'h0003, 16'h0004, 1'b0); cyc();
    chk("pre rst sum", 32'(sum), 3);
    rst = 1'b1; drive(1'b0, '0, '0, 1'b0); cyc();
    chk("rst valid", 32'(out_valid), 0);
    chk("rst sum", 32'(sum), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post rst valid", 32'(out_valid), 0);
    end

    // Saturation-sensitive vector.
    drive(1'b1, 16'hFFFF, 16'h0002, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0); cyc();
`ifdef CSA_SAT_EN
    chk("sat vec sum", 32'(sum), 32'h0FFFF);
`else
    chk("sat vec sum", 32'(sum), 32'h10001);
`endif
    chk("sat vec cnt", 32'(cout_cnt), 1);

    // Random sweep against the model, with stalls and occasional clears.
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 4) != 0);
      cnt_clr = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      cyc();
    end
    en = 1'b1; cnt_clr = 1'b0; drive(1'b0, '0, '0, 1'b0);
    cyc(); cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder; the next generation of the 2-bit combinational carry-select adder block used in the FIR datapath.
- Splits a WIDTH-bit add into SEG_WIDTH segments.
- Stage 1 registers both carry-in variants per segment. Stage 2 resolves the select chain and registers the result.
- Provides valid tagging, a stall enable and a saturating carry-out event counter, for FIR tap accumulation.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 4, carry-select segment width; NSEG = WIDTH/SEG_WIDTH, minimum 1.
- CNT_WIDTH, 8, width of the carry-out event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance enable; 0 freezes every register.
- in_valid  in  1  in1/in2/cin are valid this cycle.
- in1  in  WIDTH  unsigned operand A.
- in2  in  WIDTH  unsigned operand B.
- cin  in  1  carry into segment 0.
- out_valid  out  1  sum is valid.
- sum  out  WIDTH+1  in1+in2+cin, with the MSB as carry-out.
- cout_cnt  out  CNT_WIDTH  saturating count of valid results with sum[WIDTH]=1.
- cnt_clr  in  1  synchronous clear of cout_cnt.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, sum=0, cout_cnt=0, all internal valid bits 0, internal data registers 0. Reset overrides en and cnt_clr. Reset mid-operation discards every in-flight operation; no output follows for them.
- Stage 1 (en=1):
  - For each segment k, register s0[k] = A_k+B_k+0 and s1[k] = A_k+B_k+1, each SEG_WIDTH+1 bits.
  - Register cin and v1 = in_valid.
  - Data registers load every enabled cycle regardless of in_valid; only the valid bits are qualified.
- Stage 2 (en=1):
  - Select chain: c0 = registered cin; segment k takes s(c_k)[k] low bits; c_{k+1} = carry bit of the selected word.
  - sum = {c_NSEG, concatenated segments}; out_valid = v1.
- Latency: exactly 2 enabled clk edges from in_valid sampled high to out_valid high.
- Throughput: one operation per enabled cycle, no bubbles.
- en=0:
  - All pipeline registers and cout_cnt hold.
  - out_valid and sum stay stable; the same result is presented again and is not recounted.
  - in_valid is ignored that cycle.
- cout_cnt:
  - Increments on an enabled edge when stage-2 loads a valid result whose carry-out is 1.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - cnt_clr=1 clears it, and takes priority over a same-cycle increment.
  - cnt_clr acts even when en=0.
- Width rules: all arithmetic is unsigned. Max result 2*(2^WIDTH-1)+1 = 2^(WIDTH+1)-1 fits WIDTH+1 bits, so there is no truncation.
- NSEG=1 degenerates to a plain registered adder with the same latency.
- Invalid cycles still compute, but out_valid=0 and the counter is untouched.

Optional Feature:
- Macro CSA_SAT_EN.
- Defined: unsigned saturation of the result.
  - When the stage-2 carry-out is 1, sum = {1'b0, all ones in WIDTH bits}, i.e. 2^WIDTH-1.
  - Otherwise sum equals the normal result with sum[WIDTH]=0.
  - cout_cnt then counts saturation events. Counting uses the pre-saturation carry, with the same rules as above.
- Undefined: full WIDTH+1 result as specified above. Port list is identical in both builds.

Decomposition:
- Shared package csa_pkg holds:
  - the function computing NSEG;
  - a localparam check that WIDTH % SEG_WIDTH == 0, which errors at elaboration otherwise;
  - a segment-pair typedef/struct {s0, s1} of SEG_WIDTH+1 bits each.
- One natural sub-module: csa_seg, a combinational SEG_WIDTH adder producing s0/s1.
  - Instantiated NSEG times via generate.
  - Successor of the existing segment block.

Test Plan:
- Reset and latency (WIDTH=16, SEG_WIDTH=4, en=1): in1=0x00FF, in2=0x0001, cin=0, in_valid=1 for one cycle -> out_valid pulses exactly 2 cycles later with sum=0x00100.
- Full carry ripple: in1=0xFFFF, in2=0x0000, cin=1 -> sum=0x10000 and cout_cnt increments to 1. Same with cin=0 -> sum=0x0FFFF and no increment.
- Back-to-back stream: 4 consecutive valid ops i=0..3 with in1=in2=i, cin=1 -> sums 1,3,5,7 on 4 consecutive cycles with out_valid held high.
- Stall: hold en=0 for 3 cycles mid-stream -> outputs frozen, order preserved, cout_cnt not recounted. Assert rst mid-stream -> out_valid=0 next cycle, and no stale results appear after release.
- Counter saturation/clear (CNT_WIDTH=2): 5 carry-out ops -> cout_cnt=3. cnt_clr coincident with a carry-out result -> cout_cnt=0.
- CSA_SAT_EN build: in1=0xFFFF, in2=0x0002, cin=0 -> sum=0x0FFFF and cout_cnt increments. Random sweep vs. reference model: sum == min(in1+in2+cin, 0xFFFF).
